// File: rtl/hit_edge_collector.sv
// Per-frame collision collector: accumulates which object edges touched the
// boundary layer during a frame and publishes flags/count/frameHit at startOfFrame.
// Ports: clk/resetN; startOfFrame, objectDrawingRequest, boundaryDrawingRequest,
//   HitEdgeCode, hitAck (inputs); collision, frameHit, edgeFlags, hitPixelCount (outputs).
// Optional feature macro: HIT_STICKY_EN (frameHit held until hitAck, HOLD state).
module hit_edge_collector #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   objectDrawingRequest,
  input  logic                   boundaryDrawingRequest,
  input  logic [2:0]             HitEdgeCode,
  input  logic                   hitAck,
  output logic                   collision,
  output logic                   frameHit,
  output logic [4:0]             edgeFlags,
  output logic [COUNT_WIDTH-1:0] hitPixelCount
);

`ifdef HIT_STICKY_EN
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, COLLECT} state_t;
  logic unused_ack;
  assign unused_ack = hitAck;
`endif

  state_t                 state;
  logic [4:0]             acc_flags;
  logic [COUNT_WIDTH-1:0] acc_count;

  logic                   pix_hit;
  logic [4:0]             pix_flags;
  logic [COUNT_WIDTH-1:0] pix_count;    // reload value: this cycle's pixel alone
  logic [4:0]             next_flags;   // accumulate value
  logic [COUNT_WIDTH-1:0] next_count;
  logic                   acc_nonzero;

  assign pix_hit     = objectDrawingRequest && boundaryDrawingRequest;
  assign pix_count   = {{(COUNT_WIDTH-1){1'b0}}, pix_hit};
  assign acc_nonzero = (acc_count != '0);

  always_comb begin
    pix_flags = 5'b00000;
    if (pix_hit) begin
      case (HitEdgeCode)
        3'd0:    pix_flags = 5'b00001;
        3'd1:    pix_flags = 5'b00010;
        3'd2:    pix_flags = 5'b00100;
        3'd3:    pix_flags = 5'b01000;
        3'd4:    pix_flags = 5'b10000;
        default: pix_flags = 5'b00000;  // invalid codes count but flag nothing
      endcase
    end
  end

  always_comb begin
    next_flags = acc_flags | pix_flags;
    next_count = acc_count;
    if (pix_hit && (acc_count != '1))
      next_count = acc_count + COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= IDLE;
      acc_flags     <= '0;
      acc_count     <= '0;
      collision     <= 1'b0;
      frameHit      <= 1'b0;
      edgeFlags     <= '0;
      hitPixelCount <= '0;
    end else begin
      collision <= pix_hit;
`ifndef HIT_STICKY_EN
      frameHit  <= 1'b0;  // one-cycle pulse unless a nonzero publish below
`endif
      case (state)
        IDLE: begin
          // Pixels before the first frame boundary are ignored; the
          // boundary cycle's own pixel already belongs to the new frame.
          if (startOfFrame) begin
            state     <= COLLECT;
            acc_flags <= pix_flags;
            acc_count <= pix_count;
          end
        end

        COLLECT: begin
          if (startOfFrame) begin
            edgeFlags     <= acc_flags;
            hitPixelCount <= acc_count;
            frameHit      <= acc_nonzero;
            acc_flags     <= pix_flags;
            acc_count     <= pix_count;
`ifdef HIT_STICKY_EN
            if (acc_nonzero) state <= HOLD;
`endif
          end else begin
            acc_flags <= next_flags;
            acc_count <= next_count;
          end
        end

`ifdef HIT_STICKY_EN
        HOLD: begin
          if (startOfFrame) begin
            edgeFlags     <= acc_flags;
            hitPixelCount <= acc_count;
            acc_flags     <= pix_flags;
            acc_count     <= pix_count;
            if (hitAck) begin
              // Ack retires the old result; the new publish decides frameHit.
              frameHit <= acc_nonzero;
              state    <= acc_nonzero ? HOLD : COLLECT;
            end
            // Without ack the result is overwritten and frameHit stays high.
          end else begin
            acc_flags <= next_flags;
            acc_count <= next_count;
            if (hitAck) begin
              frameHit <= 1'b0;
              state    <= COLLECT;
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hit_edge_collector.sv
// Directed self-checking bench for hit_edge_collector (COUNT_WIDTH=8).
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
// Sticky-only steps are compiled in when HIT_STICKY_EN is defined.
module tb_hit_edge_collector;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       objectDrawingRequest;
  logic       boundaryDrawingRequest;
  logic [2:0] HitEdgeCode;
  logic       hitAck;
  logic       collision;
  logic       frameHit;
  logic [4:0] edgeFlags;
  logic [7:0] hitPixelCount;

  int checks = 0;
  int errors = 0;

  hit_edge_collector #(.COUNT_WIDTH(8)) dut (
    .clk                    (clk),
    .resetN                 (resetN),
    .startOfFrame           (startOfFrame),
    .objectDrawingRequest   (objectDrawingRequest),
    .boundaryDrawingRequest (boundaryDrawingRequest),
    .HitEdgeCode            (HitEdgeCode),
    .hitAck                 (hitAck),
    .collision              (collision),
    .frameHit               (frameHit),
    .edgeFlags              (edgeFlags),
    .hitPixelCount          (hitPixelCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel cycle: drive inputs, clock once, settle past the edge.
  task automatic cyc(input logic obj, input logic bnd, input logic [2:0] code,
                     input logic sof, input logic ack);
    objectDrawingRequest   = obj;
    boundaryDrawingRequest = bnd;
    HitEdgeCode            = code;
    startOfFrame           = sof;
    hitAck                 = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic hits(input int n, input logic [2:0] code);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, code, 1'b0, 1'b0);
  endtask

  task automatic check_pub(input string tag, input logic fh, input logic [4:0] fl,
                           input logic [7:0] cnt);
    check({tag, "_frameHit"}, 32'(frameHit), 32'(fh));
    check({tag, "_edgeFlags"}, 32'(edgeFlags), 32'(fl));
    check({tag, "_count"}, 32'(hitPixelCount), 32'(cnt));
  endtask

  initial begin
    resetN = 1'b0;
    startOfFrame = 1'b0;
    objectDrawingRequest = 1'b0;
    boundaryDrawingRequest = 1'b0;
    HitEdgeCode = 3'd0;
    hitAck = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_collision", 32'(collision), 32'd0);
    check_pub("rst", 1'b0, 5'b00000, 8'd0);
    resetN = 1'b1;

    // IDLE: 10 collision pixels before the first frame boundary are ignored.
    hits(10, 3'd1);
    check("collision_hit", 32'(collision), 32'd1);
    cyc(1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
    check("collision_obj_only", 32'(collision), 32'd0);
    cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check_pub("idle_first_sof", 1'b0, 5'b00000, 8'd0);

    // Frame with codes 0, 2, 6 interleaved with non-collision pixels.
    cyc(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 3'd3, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 3'd6, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    check_pub("three_hits", 1'b1, 5'b00101, 8'd3);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
`ifdef HIT_STICKY_EN
    check("three_hits_sticky", 32'(frameHit), 32'd1);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    check("three_hits_ack", 32'(frameHit), 32'd0);
`else
    check("three_hits_pulse_end", 32'(frameHit), 32'd0);
`endif
    check("three_hits_flags_hold", 32'(edgeFlags), 32'h05);
    check("three_hits_count_hold", 32'(hitPixelCount), 32'd3);

    // 300 code-3 pixels saturate the 8-bit count.
    hits(300, 3'd3);
    cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    check_pub("saturate", 1'b1, 5'b01000, 8'd255);
`ifdef HIT_STICKY_EN
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
`else
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
`endif
    check("saturate_fh_clear", 32'(frameHit), 32'd0);

    // Code-4 pixel in the boundary cycle belongs to the next frame.
    cyc(1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
    check_pub("sof_pixel_excl", 1'b0, 5'b00000, 8'd0);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    check_pub("sof_pixel_next", 1'b1, 5'b10000, 8'd1);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

`ifdef HIT_STICKY_EN
    // Unacknowledged result is overwritten by the next hit frame.
    check("hold_before_ack", 32'(frameHit), 32'd1);
    hits(2, 3'd1);
    cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    check_pub("overwrite", 1'b1, 5'b00010, 8'd2);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("overwrite_still", 32'(frameHit), 32'd1);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    check("overwrite_ack", 32'(frameHit), 32'd0);
`endif

    // Reset mid-frame after 5 hits: everything clears, next boundary publishes nothing.
    hits(5, 3'd2);
    resetN = 1'b0;
    #1;
    check("midrst_collision", 32'(collision), 32'd0);
    check_pub("midrst", 1'b0, 5'b00000, 8'd0);
    @(posedge clk); #1;
    resetN = 1'b1;
    hits(3, 3'd0);
    cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    check_pub("midrst_sof", 1'b0, 5'b00000, 8'd0);
    hits(1, 3'd1);
    cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    check_pub("after_rst_frame", 1'b1, 5'b00010, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hit_edge_collector.md
# hit_edge_collector

Per-frame collision collector on the consumer side of the bitmap drawers' hit-edge interface. Each pixel cycle it samples the moving object's drawing request and 3-bit hit-edge code together with the boundary layer's drawing request. It accumulates which edges of the object touched a boundary during the frame. At each frame boundary it publishes the result to the object-movement logic as edge flags, a collision-pixel count and a frame-hit indication.

## Interface
Parameters:
- COUNT_WIDTH, 8, width of the saturating collision-pixel counter

Ports:
- clk  in  1  pixel clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  single-cycle pulse at the frame boundary
- objectDrawingRequest  in  1  object bitmap pixel is opaque
- boundaryDrawingRequest  in  1  boundary layer pixel is opaque
- HitEdgeCode  in  3  object edge code, cycle-aligned with objectDrawingRequest: 0 bottom, 1 left, 2 right, 3 top, 4 corner, 5-7 invalid
- hitAck  in  1  consumer acknowledge; used only with HIT_STICKY_EN
- collision  out  1  registered per-pixel collision, for debug/scoring
- frameHit  out  1  published frame contained at least one collision pixel
- edgeFlags  out  5  published flags: [0] bottom, [1] left, [2] right, [3] top, [4] corner
- hitPixelCount  out  COUNT_WIDTH  published collision-pixel count, saturating

## Operation
- Collision pixel: objectDrawingRequest && boundaryDrawingRequest.
- Accumulators: accFlags[4:0] and accCount. On each collision pixel with code c ≤ 4, set accFlags[c]. Increment accCount for codes 0-7 and saturate at 2^COUNT_WIDTH−1. Codes 5-7 set no flag.
- State machine:
  - IDLE: entered from reset. Pixels are ignored and accumulators stay 0. On startOfFrame, go to COLLECT. Nothing is published.
  - COLLECT: accumulate. On startOfFrame, publish accFlags/accCount to edgeFlags/hitPixelCount. Then reload the accumulators with the current cycle's pixel contribution, or zero if it is not a collision pixel.
  - HOLD (HIT_STICKY_EN only): entered on a publish with a nonzero count. Accumulation continues. hitAck returns to COLLECT. Another startOfFrame republishes (overwrite) and the state stays HOLD.
- A pixel sampled in the startOfFrame cycle belongs to the new frame.
- frameHit is asserted only for publishes with hitPixelCount ≠ 0. A zero-count publish still updates edgeFlags and hitPixelCount, to 0.
- Reset mid-frame discards the accumulators and any held result and returns to IDLE.

## Timing
- Reset values: collision=0, frameHit=0, edgeFlags=0, hitPixelCount=0, accumulators=0, state IDLE.
- collision: 1-cycle latency from the sampled inputs.
- Accumulation: a pixel sampled in cycle t is reflected in the accumulators at t+1.
- Publish: startOfFrame in cycle t → edgeFlags, hitPixelCount and frameHit valid at t+1.
- edgeFlags and hitPixelCount hold until the next publish.
- Without HIT_STICKY_EN: frameHit is high for exactly cycle t+1.
- With HIT_STICKY_EN: frameHit rises at t+1 and stays high until the cycle after hitAck is sampled high.
- hitAck while frameHit=0 is ignored.
- hitAck and startOfFrame in the same cycle: the ack retires the old result and the new result is published. frameHit at t+1 follows the new count.
- startOfFrame while in HOLD without hitAck: the result is overwritten and frameHit stays high.

## Configuration
- HIT_STICKY_EN defined: HOLD state and the hitAck handshake are compiled in, and frameHit is level until acknowledged.
- HIT_STICKY_EN undefined: no HOLD state, hitAck is unused, and frameHit is a one-cycle pulse per nonzero publish.

## Test plan
- Reset, then 10 collision pixels with code 1 before the first startOfFrame → after the first startOfFrame: frameHit=0, edgeFlags=0, hitPixelCount=0.
- One frame with 3 collision pixels: code 0, code 2 and code 6, then startOfFrame → next cycle edgeFlags=5'b00101, hitPixelCount=3, frameHit=1.
  - Without HIT_STICKY_EN, frameHit=0 one cycle later.
- One frame with 300 collision pixels of code 3, COUNT_WIDTH=8 → hitPixelCount=255, edgeFlags=5'b01000.
- Collision pixel with code 4 in the same cycle as startOfFrame → published count excludes it. The next publish has edgeFlags=5'b10000, hitPixelCount=1.
- HIT_STICKY_EN: hit frame, no hitAck for 2 frames (second frame has 2 code-1 hits) → frameHit stays 1 and edgeFlags=5'b00010, hitPixelCount=2. hitAck pulse → frameHit=0 on the following cycle.
- Assert resetN=0 mid-frame after 5 hits → all outputs 0 and IDLE. The next startOfFrame publishes nothing.
